// File: rtl/alu_seq_pkg.sv
// Shared types and default sizing for the ALU control-word sequencer.
// The optional abort input is enabled by the ALU_SEQ_ABORT_EN macro.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int ALU_SEQ_W     = 6;
    localparam int ALU_SEQ_DEPTH = 16;

endpackage

// File: rtl/alu_seq_table.sv
// DEPTH x W control-word register file: synchronous write and clear,
// combinational read.
module alu_seq_table
    import alu_seq_pkg::*;
#(
    parameter int W     = ALU_SEQ_W,
    parameter int DEPTH = ALU_SEQ_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (int'(wr_addr) < DEPTH)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Indices beyond the populated range read as an idle word.
    always_comb begin
        rd_data = '0;
        if (int'(rd_addr) < DEPTH) begin
            rd_data = mem[rd_addr];
        end
    end

endmodule

// File: rtl/alu_seq_controller.sv
// Table-driven ALU control-word sequencer with start/busy/done handshake.
// Define ALU_SEQ_ABORT_EN to add the abort input that cancels a run.
module alu_seq_controller
    import alu_seq_pkg::*;
#(
    parameter  int W     = ALU_SEQ_W,
    parameter  int DEPTH = ALU_SEQ_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cfg_we,
    input  logic [AW-1:0] cfg_addr,
    input  logic [W-1:0]  cfg_data,
    input  logic [AW-1:0] last_idx,
    input  logic          loop_en,
    input  logic          start,
    input  logic          hold,
`ifdef ALU_SEQ_ABORT_EN
    input  logic          abort,
`endif
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] step,
    output logic [W-1:0]  w
);

    state_t        state_q;
    state_t        state_d;
    logic [AW-1:0] step_d;
    logic [AW-1:0] last_q;
    logic [AW-1:0] last_d;
    logic          loop_q;
    logic          loop_d;
    logic          busy_d;
    logic          done_d;
    logic [W-1:0]  w_d;
    logic [W-1:0]  rd_data;
    logic          tbl_we;
    logic          abort_req;

`ifdef ALU_SEQ_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // Table is frozen while a sequence runs; start takes priority.
    assign tbl_we = cfg_we && !start && (state_q != RUN);

    alu_seq_table #(
        .W     (W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_table (
        .clk     (clk),
        .reset   (reset),
        .we      (tbl_we),
        .wr_addr (cfg_addr),
        .wr_data (cfg_data),
        .rd_addr (step_d),
        .rd_data (rd_data)
    );

    always_comb begin
        state_d = state_q;
        step_d  = step;
        last_d  = last_q;
        loop_d  = loop_q;
        busy_d  = busy;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    state_d = RUN;
                    step_d  = '0;
                    busy_d  = 1'b1;
                    loop_d  = loop_en;
                    if (int'(last_idx) > DEPTH - 1) begin
                        last_d = AW'(DEPTH - 1);
                    end else begin
                        last_d = last_idx;
                    end
                end
            end
            RUN: begin
                if (abort_req) begin
                    state_d = IDLE;
                    step_d  = '0;
                    busy_d  = 1'b0;
                end else if (!hold) begin
                    if (step != last_q) begin
                        step_d = step + AW'(1);
                    end else if (loop_q) begin
                        step_d = '0;
                    end else begin
                        state_d = DONE;
                        step_d  = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                step_d  = '0;
                busy_d  = 1'b0;
            end
        endcase
        w_d = (state_d == RUN) ? rd_data : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            step    <= '0;
            last_q  <= '0;
            loop_q  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            w       <= '0;
        end else begin
            state_q <= state_d;
            step    <= step_d;
            last_q  <= last_d;
            loop_q  <= loop_d;
            busy    <= busy_d;
            done    <= done_d;
            w       <= w_d;
        end
    end

endmodule
